ram_bus_arbiter: RTL and testbench
==================================

Name: ram_bus_arbiter

Overview:
Time-slot arbiter for the 3-lane video/program RAM (3 lanes × 16K × 8, 14-bit address + 2-bit lane select).
- Each E period is split into two halves:
  - Video slot: a fixed read of all three lanes for the refresh.
  - Bus slot: given to either the MPU or the blitter.
- The blitter takes the bus through a HALT/BA handshake with the 6809.
- The block sits between the MPU address decoder output (14-bit RAM address, lane select, RAM-access qualifier), the video counter, the blitter, and the physical RAM port.

Parameters:
SLOT_CYCLES, 6, clk cycles per half-slot (12 MHz clk, 1 MHz E); minimum 2.
RD_LATENCY, 1, clk cycles from ram_addr issue to valid ram_rdata; must be < SLOT_CYCLES.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
mpu_e  out  1  E clock enable level; high during the bus half-slot
mpu_racnt  in  1  MPU RAM access qualifier (decoded, VMA-qualified)
mpu_ram_addr  in  14  MPU RAM row/column address
mpu_lane_sel  in  2  MPU lane: 0..2 select a lane, 3 = no RAM
mpu_r_w_n  in  1  MPU read/write_n
mpu_wdata  in  8  MPU write data
mpu_rdata  out  8  MPU read data, held until the next MPU read
mpu_halt  out  1  HALT request to the 6809
mpu_ba  in  1  6809 bus-available, already synchronised
video_addr  in  14  refresh address
video_data  out  24  lanes {2,1,0} read data
video_valid  out  1  one-cycle strobe when video_data updates
blt_req  in  1  blitter wants the bus
blt_gnt  out  1  blitter owns the bus-slot
blt_valid  in  1  blitter has an access pending this slot
blt_ram_addr  in  14  blitter address
blt_lane_sel  in  2  blitter lane (3 = none)
blt_we  in  1  blitter write
blt_wdata  in  8  blitter write data
blt_nib_inh  in  2  write inhibit {hi, lo} nibble
blt_rdata  out  8  blitter read data
blt_ack  out  1  one-cycle strobe: access complete
ram_addr  out  14  RAM address
ram_lane_en  out  3  per-lane enable
ram_we  out  3  per-lane write enable
ram_nib_inh  out  2  nibble write inhibit
ram_wdata  out  8  write data
ram_rdata  in  24  lane read data

Behaviour:
- Phase counter runs 0..2*SLOT_CYCLES-1 and wraps.
- mpu_e = (phase >= SLOT_CYCLES).
- Reset clears the phase to 0 and the state to IDLE. All outputs go to 0, including data registers.
- Video slot:
  - At phase 0: ram_addr=video_addr, ram_lane_en=3'b111, ram_we=0.
  - At phase RD_LATENCY: capture ram_rdata into video_data; pulse video_valid.
  - The video slot is never skipped or stolen.
- Bus slot, issued at phase SLOT_CYCLES for exactly one cycle:
  - The owner is the MPU in IDLE, HALT_WAIT and RELEASE; it is the blitter in BLIT.
  - MPU: access occurs only if mpu_racnt=1 and mpu_lane_sel!=3. Lane enable = onehot(lane_sel); ram_we = onehot if !mpu_r_w_n; ram_nib_inh=0.
  - Blitter: access occurs only if blt_valid=1. Same lane rule, with ram_nib_inh=blt_nib_inh.
  - blt_lane_sel=3 still completes (blt_ack pulses) but enables nothing.
  - At phase SLOT_CYCLES+RD_LATENCY: reads capture the selected lane byte into mpu_rdata or blt_rdata. blt_ack pulses for any performed blitter access, read or write.
- Outside issue cycles: ram_lane_en=0, ram_we=0, ram_addr holds its last value.
- State machine:
  - IDLE: blt_req=1 -> HALT_WAIT with mpu_halt=1.
  - HALT_WAIT: mpu_ba=1 -> BLIT with blt_gnt=1. blt_req dropping here -> RELEASE.
  - BLIT: blt_req=0 -> RELEASE; mpu_halt=0 and blt_gnt=0 on the same edge.
  - RELEASE: mpu_ba=0 -> IDLE.
  - blt_req reasserted during RELEASE waits for IDLE (no direct re-grant).
- Grant never changes mid-access:
  - Transitions into or out of BLIT are taken only while phase is in the video half (mpu_e=0). Otherwise they are deferred.
  - A blitter access issued at SLOT_CYCLES always completes its capture and ack.
- mpu_racnt is ignored in BLIT.
- Simultaneous blt_req fall and blt_valid in the same bus slot: the access is performed first, then RELEASE.
- Synchronous reset mid-access aborts it. No ack, no data update.

Decomposition:
Package ram_arbiter_pkg:
- state enum {IDLE, HALT_WAIT, BLIT, RELEASE}
- LANE_NONE=2'd3
- onehot lane function
- phase-width helper function

Sub-module ram_slot_timer:
- phase counter
- outputs: mpu_e, video_issue, video_capture, bus_issue, bus_capture, in_video_half

Test Plan:
- Reset, free-run 24 cycles, video_addr=14'h0123, ram_rdata=24'hA5B6C7 -> video_valid at phases 1 and 13; video_data=24'hA5B6C7; ram_lane_en=3'b111 only at phases 0 and 12.
- MPU write: racnt=1, lane=1, addr=14'h0040, wdata=8'h3C, r_w_n=0 -> at phase 6: ram_lane_en=3'b010, ram_we=3'b010, ram_wdata=8'h3C. MPU read of lane 2 with ram_rdata[23:16]=8'h7E -> mpu_rdata=8'h7E at phase 7.
- lane_sel=3 with racnt=1 -> no ram_lane_en/ram_we in the bus slot; mpu_rdata unchanged.
- blt_req=1 -> mpu_halt next cycle. mpu_ba=1 after 20 cycles -> blt_gnt rises only in the video half. Three blt writes with nib_inh=2'b01 -> three blt_ack, ram_nib_inh=2'b01. Video reads continue every period.
- blt_req drops while blt_valid is pending -> final access acked. Then mpu_halt=0 and blt_gnt=0; IDLE after mpu_ba=0. blt_req pulsed during RELEASE -> mpu_halt reasserts only after IDLE.
- reset asserted at phase 6 during a blitter read -> no blt_ack; all outputs 0 next cycle; phase restarts at 0.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types and helpers for the 3-lane video/program RAM arbiter.
// Contents: arbiter state enum, the "no RAM" lane code, lane decode helpers
// and the phase counter width helper.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HALT_WAIT = 2'd1,
    BLIT      = 2'd2,
    RELEASE   = 2'd3
  } arb_state_t;

  localparam logic [1:0] LANE_NONE = 2'd3;

  // Lane select to per-lane enable; LANE_NONE enables nothing.
  function automatic logic [2:0] lane_onehot(input logic [1:0] lane);
    case (lane)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Byte of the 24-bit lane read bus belonging to one lane.
  function automatic logic [7:0] lane_byte(input logic [23:0] data, input logic [1:0] lane);
    case (lane)
      2'd0:    return data[7:0];
      2'd1:    return data[15:8];
      default: return data[23:16];
    endcase
  endfunction

  // Bits needed to count 0..count-1 (at least one).
  function automatic int phase_width(input int count);
    int w;
    w = 1;
    while ((1 << w) < count) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/ram_slot_timer.sv
// Phase counter for the two half-slots of one E period.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   mpu_e           high during the bus half-slot
//   video_issue     phase 0: video read is presented to the RAM
//   video_capture   cycle whose closing edge samples the video read data
//   bus_issue       phase SLOT_CYCLES: bus-slot access is presented
//   bus_capture     cycle whose closing edge samples the bus read data
//   in_video_half   a state change taken at the closing edge of this cycle
//                   both leaves from and lands in the video half
module ram_slot_timer
  import ram_arbiter_pkg::*;
#(
  parameter int SLOT_CYCLES = 6,
  parameter int RD_LATENCY  = 1
) (
  input  logic clk,
  input  logic reset,
  output logic mpu_e,
  output logic video_issue,
  output logic video_capture,
  output logic bus_issue,
  output logic bus_capture,
  output logic in_video_half
);

  localparam int PERIOD = 2 * SLOT_CYCLES;
  localparam int PW     = phase_width(PERIOD);

  localparam logic [PW-1:0] LAST   = PW'(PERIOD - 1);
  localparam logic [PW-1:0] SLOT   = PW'(SLOT_CYCLES);
  localparam logic [PW-1:0] WIN    = PW'(SLOT_CYCLES - 1);
  // Captured data becomes visible RD_LATENCY cycles after issue, so the
  // sampling edge closes the cycle just before that.
  localparam logic [PW-1:0] V_CAP  = PW'(RD_LATENCY - 1);
  localparam logic [PW-1:0] B_CAP  = PW'(SLOT_CYCLES + RD_LATENCY - 1);

  logic [PW-1:0] phase;

  always_ff @(posedge clk) begin
    if (reset)              phase <= '0;
    else if (phase == LAST) phase <= '0;
    else                    phase <= phase + PW'(1);
  end

  assign mpu_e         = (phase >= SLOT);
  assign video_issue   = (phase == '0);
  assign video_capture = (phase == V_CAP);
  assign bus_issue     = (phase == SLOT);
  assign bus_capture   = (phase == B_CAP);
  assign in_video_half = (phase < WIN);

endmodule

// File: rtl/ram_bus_arbiter.sv
// Time-slot arbiter for the 3-lane video/program RAM.
// The video half of each E period reads all three lanes for refresh; the bus
// half serves either the 6809 or, after a HALT/BA handshake, the blitter.
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   mpu_*                      6809 side: E level, RAM request, read data, HALT/BA
//   video_addr/data/valid      refresh address in, lane {2,1,0} data out
//   blt_*                      blitter request/grant and one access per bus slot
//   ram_*                      physical RAM port
//
// state     | meaning
// IDLE      | MPU owns the bus slot, no blitter request
// HALT_WAIT | HALT asserted, waiting for BA; MPU still owns the slot
// BLIT      | blitter owns the bus slot
// RELEASE   | HALT dropped, waiting for BA to fall; MPU owns the slot
module ram_bus_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int SLOT_CYCLES = 6,
  parameter int RD_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mpu_e,
  input  logic        mpu_racnt,
  input  logic [13:0] mpu_ram_addr,
  input  logic [1:0]  mpu_lane_sel,
  input  logic        mpu_r_w_n,
  input  logic [7:0]  mpu_wdata,
  output logic [7:0]  mpu_rdata,
  output logic        mpu_halt,
  input  logic        mpu_ba,
  input  logic [13:0] video_addr,
  output logic [23:0] video_data,
  output logic        video_valid,
  input  logic        blt_req,
  output logic        blt_gnt,
  input  logic        blt_valid,
  input  logic [13:0] blt_ram_addr,
  input  logic [1:0]  blt_lane_sel,
  input  logic        blt_we,
  input  logic [7:0]  blt_wdata,
  input  logic [1:0]  blt_nib_inh,
  output logic [7:0]  blt_rdata,
  output logic        blt_ack,
  output logic [13:0] ram_addr,
  output logic [2:0]  ram_lane_en,
  output logic [2:0]  ram_we,
  output logic [1:0]  ram_nib_inh,
  output logic [7:0]  ram_wdata,
  input  logic [23:0] ram_rdata
);

  logic video_issue, video_capture, bus_issue, bus_capture, in_video_half;

  ram_slot_timer #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .RD_LATENCY  (RD_LATENCY)
  ) u_timer (
    .clk           (clk),
    .reset         (reset),
    .mpu_e         (mpu_e),
    .video_issue   (video_issue),
    .video_capture (video_capture),
    .bus_issue     (bus_issue),
    .bus_capture   (bus_capture),
    .in_video_half (in_video_half)
  );

  arb_state_t state, state_next;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Entering or leaving BLIT waits for in_video_half so ownership is fixed
  // from one bus-slot issue through its capture.
  always_comb begin
    state_next = state;
    mpu_halt   = 1'b0;
    blt_gnt    = 1'b0;
    case (state)
      IDLE: begin
        if (blt_req) state_next = HALT_WAIT;
      end
      HALT_WAIT: begin
        mpu_halt = 1'b1;
        if (!blt_req)                      state_next = RELEASE;
        else if (mpu_ba && in_video_half)  state_next = BLIT;
      end
      BLIT: begin
        mpu_halt = 1'b1;
        blt_gnt  = 1'b1;
        if (!blt_req && in_video_half) state_next = RELEASE;
      end
      RELEASE: begin
        if (!mpu_ba) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  logic        blt_owner, bus_req, bus_write, bus_go, vid_go;
  logic [13:0] bus_addr, addr_q;
  logic [1:0]  bus_lane;

  assign blt_owner = (state == BLIT);
  assign bus_addr  = blt_owner ? blt_ram_addr : mpu_ram_addr;
  assign bus_lane  = blt_owner ? blt_lane_sel : mpu_lane_sel;
  assign bus_write = blt_owner ? blt_we : !mpu_r_w_n;
  // A blitter access to LANE_NONE still runs so that it gets acknowledged.
  assign bus_req   = blt_owner ? blt_valid : (mpu_racnt && (mpu_lane_sel != LANE_NONE));
  // Issue strobes are gated by reset so the port is quiet while it is held.
  assign vid_go    = video_issue && !reset;
  assign bus_go    = bus_issue && bus_req && !reset;

  always_comb begin
    ram_addr    = addr_q;
    ram_lane_en = 3'b000;
    ram_we      = 3'b000;
    ram_nib_inh = 2'b00;
    ram_wdata   = 8'h00;
    if (vid_go) begin
      ram_addr    = video_addr;
      ram_lane_en = 3'b111;
    end else if (bus_go) begin
      ram_addr    = bus_addr;
      ram_lane_en = lane_onehot(bus_lane);
      if (bus_write) begin
        ram_we    = lane_onehot(bus_lane);
        ram_wdata = blt_owner ? blt_wdata : mpu_wdata;
      end
      if (blt_owner) ram_nib_inh = blt_nib_inh;
    end
  end

  // Outstanding bus access; when RD_LATENCY is 1 the capture falls in the
  // issue cycle itself, so the live request is used directly.
  logic       pend_valid, pend_blt, pend_read;
  logic [1:0] pend_lane;
  logic       cap_valid, cap_blt, cap_read;
  logic [1:0] cap_lane;

  assign cap_valid = bus_go || pend_valid;
  assign cap_blt   = bus_go ? blt_owner  : pend_blt;
  assign cap_read  = bus_go ? !bus_write : pend_read;
  assign cap_lane  = bus_go ? bus_lane   : pend_lane;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      pend_valid  <= 1'b0;
      pend_blt    <= 1'b0;
      pend_read   <= 1'b0;
      pend_lane   <= 2'd0;
      video_data  <= '0;
      video_valid <= 1'b0;
      mpu_rdata   <= '0;
      blt_rdata   <= '0;
      blt_ack     <= 1'b0;
    end else begin
      addr_q      <= ram_addr;
      video_valid <= 1'b0;
      blt_ack     <= 1'b0;
      if (bus_go) begin
        pend_valid <= 1'b1;
        pend_blt   <= blt_owner;
        pend_read  <= !bus_write;
        pend_lane  <= bus_lane;
      end
      if (video_capture) begin
        video_data  <= ram_rdata;
        video_valid <= 1'b1;
      end
      if (bus_capture && cap_valid) begin
        pend_valid <= 1'b0;
        if (cap_read && (cap_lane != LANE_NONE)) begin
          if (cap_blt) blt_rdata <= lane_byte(ram_rdata, cap_lane);
          else         mpu_rdata <= lane_byte(ram_rdata, cap_lane);
        end
        if (cap_blt) blt_ack <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
module tb_ram_bus_arbiter;

  localparam int SLOT   = 6;
  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mpu_e;
  logic        mpu_racnt = 1'b0;
  logic [13:0] mpu_ram_addr = '0;
  logic [1:0]  mpu_lane_sel = 2'd3;
  logic        mpu_r_w_n = 1'b1;
  logic [7:0]  mpu_wdata = '0;
  logic [7:0]  mpu_rdata;
  logic        mpu_halt;
  logic        mpu_ba = 1'b0;
  logic [13:0] video_addr = '0;
  logic [23:0] video_data;
  logic        video_valid;
  logic        blt_req = 1'b0;
  logic        blt_gnt;
  logic        blt_valid = 1'b0;
  logic [13:0] blt_ram_addr = '0;
  logic [1:0]  blt_lane_sel = 2'd0;
  logic        blt_we = 1'b0;
  logic [7:0]  blt_wdata = '0;
  logic [1:0]  blt_nib_inh = '0;
  logic [7:0]  blt_rdata;
  logic        blt_ack;
  logic [13:0] ram_addr;
  logic [2:0]  ram_lane_en;
  logic [2:0]  ram_we;
  logic [1:0]  ram_nib_inh;
  logic [7:0]  ram_wdata;
  logic [23:0] ram_rdata = '0;

  ram_bus_arbiter #(.SLOT_CYCLES(SLOT), .RD_LATENCY(RD_LAT)) dut (
    .clk(clk), .reset(reset), .mpu_e(mpu_e), .mpu_racnt(mpu_racnt),
    .mpu_ram_addr(mpu_ram_addr), .mpu_lane_sel(mpu_lane_sel), .mpu_r_w_n(mpu_r_w_n),
    .mpu_wdata(mpu_wdata), .mpu_rdata(mpu_rdata), .mpu_halt(mpu_halt), .mpu_ba(mpu_ba),
    .video_addr(video_addr), .video_data(video_data), .video_valid(video_valid),
    .blt_req(blt_req), .blt_gnt(blt_gnt), .blt_valid(blt_valid), .blt_ram_addr(blt_ram_addr),
    .blt_lane_sel(blt_lane_sel), .blt_we(blt_we), .blt_wdata(blt_wdata),
    .blt_nib_inh(blt_nib_inh), .blt_rdata(blt_rdata), .blt_ack(blt_ack),
    .ram_addr(ram_addr), .ram_lane_en(ram_lane_en), .ram_we(ram_we),
    .ram_nib_inh(ram_nib_inh), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_acks   = 0;
  int tb_phase = 0;

  logic [29:0] port_q[$];
  logic [23:0] vid_q[$];
  logic [8:0]  ack_q[$];
  logic [7:0]  mrd_q[$];

  logic [23:0] exp_video = '0;
  logic [7:0]  exp_mpu   = '0;
  logic [7:0]  exp_blt   = '0;
  logic [13:0] exp_hold  = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] oh(input logic [1:0] l);
    return (l == 2'd3) ? 3'b000 : (3'b001 << l);
  endfunction

  function automatic logic [7:0] sel_byte(input logic [23:0] d, input logic [1:0] l);
    logic [23:0] s;
    s = d >> (8 * l);
    return s[7:0];
  endfunction

  // Reference phase, updated on the same edge as the design.
  always @(posedge clk) begin
    if (reset)                   tb_phase <= 0;
    else if (tb_phase == 2*SLOT-1) tb_phase <= 0;
    else                         tb_phase <= tb_phase + 1;
  end

  // Monitor: compares every cycle against the scoreboard queues.
  always @(negedge clk) begin
    if (!reset) begin
      check_val("mpu_e", mpu_e, (tb_phase >= SLOT));
      if (tb_phase == 0) begin
        check_val("video_issue", {ram_addr, ram_lane_en, ram_we, ram_nib_inh, ram_wdata},
                  {video_addr, 3'b111, 3'b000, 2'b00, 8'h00});
        exp_hold = video_addr;
        vid_q.push_back(ram_rdata);
      end else if (tb_phase == SLOT && port_q.size() > 0) begin
        logic [29:0] e;
        e = port_q.pop_front();
        check_val("bus_issue", {ram_addr, ram_lane_en, ram_we, ram_nib_inh, ram_wdata}, e);
        exp_hold = e[29:16];
      end else begin
        check_val("port_quiet", {ram_addr, ram_lane_en, ram_we, ram_nib_inh, ram_wdata},
                  {exp_hold, 16'h0000});
      end

      if (tb_phase == RD_LAT) begin
        check_val("video_valid", video_valid, 1'b1);
        if (vid_q.size() > 0) exp_video = vid_q.pop_front();
      end else begin
        check_val("video_valid_idle", video_valid, 1'b0);
      end
      check_val("video_data", video_data, exp_video);

      if (blt_ack) n_acks++;
      if (tb_phase == SLOT + RD_LAT && ack_q.size() > 0) begin
        logic [8:0] a;
        a = ack_q.pop_front();
        check_val("blt_ack", blt_ack, 1'b1);
        if (a[8]) exp_blt = a[7:0];
      end else begin
        check_val("blt_ack_idle", blt_ack, 1'b0);
      end
      if (tb_phase == SLOT + RD_LAT && mrd_q.size() > 0) exp_mpu = mrd_q.pop_front();
      check_val("mpu_rdata", mpu_rdata, exp_mpu);
      check_val("blt_rdata", blt_rdata, exp_blt);
    end
  end

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tb_phase != p && n < 30);
    if (tb_phase != p) check_val("wait_phase", tb_phase, p);
  endtask

  task automatic mpu_access(input logic [1:0] lane, input logic [13:0] addr, input logic rw_n,
                            input logic [7:0] wd, input logic [23:0] rd, input bit owned);
    wait_phase(SLOT - 1);
    #1;
    mpu_racnt = 1'b1; mpu_lane_sel = lane; mpu_ram_addr = addr;
    mpu_r_w_n = rw_n; mpu_wdata = wd; ram_rdata = rd;
    if (owned && lane != 2'd3) begin
      port_q.push_back({addr, oh(lane), rw_n ? 3'b000 : oh(lane), 2'b00, rw_n ? 8'h00 : wd});
      if (rw_n) mrd_q.push_back(sel_byte(rd, lane));
    end
    wait_phase(SLOT + RD_LAT);
    #1;
    mpu_racnt = 1'b0;
  endtask

  task automatic blt_access(input logic [1:0] lane, input logic [13:0] addr, input logic we,
                            input logic [7:0] wd, input logic [1:0] nib, input logic [23:0] rd,
                            input bit drop_req);
    wait_phase(SLOT - 1);
    #1;
    blt_valid = 1'b1; blt_lane_sel = lane; blt_ram_addr = addr;
    blt_we = we; blt_wdata = wd; blt_nib_inh = nib; ram_rdata = rd;
    if (drop_req) blt_req = 1'b0;
    port_q.push_back({addr, oh(lane), we ? oh(lane) : 3'b000, nib, we ? wd : 8'h00});
    ack_q.push_back({(!we && lane != 2'd3), sel_byte(rd, lane)});
    wait_phase(SLOT + RD_LAT);
    #1;
    blt_valid = 1'b0;
  endtask

  task automatic wait_gnt();
    int n;
    n = 0;
    while (!blt_gnt && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_val("gnt_rise", blt_gnt, 1'b1);
    check_val("gnt_in_video_half", (tb_phase >= 1 && tb_phase < SLOT), 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks_before;
    int n;
    video_addr = 14'h0123;
    ram_rdata  = 24'hA5B6C7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_ctrl", {mpu_e, mpu_halt, video_valid, blt_gnt, blt_ack, ram_addr,
                             ram_lane_en, ram_we, ram_nib_inh, ram_wdata}, '0);
    check_val("reset_data", {mpu_rdata, video_data, blt_rdata}, '0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (24) @(posedge clk);

    // MPU accesses
    mpu_access(2'd1, 14'h0040, 1'b0, 8'h3C, 24'hA5B6C7, 1'b1);
    mpu_access(2'd2, 14'h0041, 1'b1, 8'h00, 24'h7EB6C7, 1'b1);
    mpu_access(2'd3, 14'h0042, 1'b1, 8'h00, 24'h112233, 1'b1);
    video_addr = 14'h2ABC;
    mpu_access(2'd0, 14'h3FFF, 1'b1, 8'h00, 24'h112233, 1'b1);

    // Blitter takes the bus
    @(negedge clk);
    #1 blt_req = 1'b1;
    @(negedge clk);
    check_val("halt_after_req", {mpu_halt, blt_gnt}, 2'b10);
    repeat (20) @(negedge clk);
    check_val("no_gnt_before_ba", blt_gnt, 1'b0);
    #1 mpu_ba = 1'b1;
    wait_gnt();
    acks_before = n_acks;
    blt_access(2'd0, 14'h0100, 1'b1, 8'hA1, 2'b01, 24'h000000, 1'b0);
    blt_access(2'd1, 14'h0101, 1'b1, 8'hB2, 2'b01, 24'h000000, 1'b0);
    blt_access(2'd2, 14'h0102, 1'b1, 8'hC3, 2'b01, 24'h000000, 1'b0);
    check_val("blt_write_acks", n_acks - acks_before, 3);
    mpu_access(2'd0, 14'h0200, 1'b0, 8'h55, 24'h000000, 1'b0);
    blt_access(2'd1, 14'h0103, 1'b0, 8'h00, 2'b00, 24'h005A00, 1'b0);
    blt_access(2'd3, 14'h0104, 1'b1, 8'h99, 2'b10, 24'h000000, 1'b0);
    blt_access(2'd2, 14'h0105, 1'b0, 8'h00, 2'b00, 24'hC30000, 1'b1);

    // Release after the final access
    n = 0;
    while (mpu_halt && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_val("release_halt", {mpu_halt, blt_gnt}, 2'b00);
    check_val("release_in_video_half", (tb_phase >= 1 && tb_phase < SLOT), 1'b1);
    check_val("blt_total_acks", n_acks - acks_before, 6);
    #1 blt_req = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_val("no_regrant_in_release", mpu_halt, 1'b0);
    end
    #1 mpu_ba = 1'b0;
    @(negedge clk);
    check_val("idle_halt_low", mpu_halt, 1'b0);
    @(negedge clk);
    check_val("halt_after_idle", mpu_halt, 1'b1);
    #1 mpu_ba = 1'b1;
    wait_gnt();

    // Reset in the middle of a blitter read
    wait_phase(SLOT - 1);
    #1;
    blt_valid = 1'b1; blt_lane_sel = 2'd0; blt_we = 1'b0; ram_rdata = 24'h0000EE;
    reset = 1'b1;
    acks_before = n_acks;
    exp_video = '0; exp_mpu = '0; exp_blt = '0; exp_hold = '0;
    port_q.delete(); vid_q.delete(); ack_q.delete(); mrd_q.delete();
    @(negedge clk);
    check_val("abort_no_issue", {ram_lane_en, ram_we}, 6'b0);
    @(posedge clk);
    #1;
    blt_req = 1'b0; mpu_ba = 1'b0; blt_valid = 1'b0;
    @(negedge clk);
    check_val("abort_ctrl", {mpu_e, mpu_halt, video_valid, blt_gnt, blt_ack, ram_addr,
                             ram_lane_en, ram_we, ram_nib_inh, ram_wdata}, '0);
    check_val("abort_data", {mpu_rdata, video_data, blt_rdata}, '0);
    check_val("abort_no_ack", n_acks - acks_before, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (14) @(negedge clk);
    mpu_access(2'd1, 14'h0777, 1'b1, 8'h00, 24'h00D400, 1'b1);
    wait_phase(3);

    check_val("port_q_empty", port_q.size(), 0);
    check_val("vid_q_empty", vid_q.size(), 0);
    check_val("ack_q_empty", ack_q.size(), 0);
    check_val("mrd_q_empty", mrd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
